// File: rtl/_riscv_defines.sv
// Shared types and opcode constants for the multicycle RV32I core.
package _riscv_defines;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        EXECUTE   = 3'd3,
        MEMORY    = 3'd4,
        WRITEBACK = 3'd5
    } state_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_I_TYPE = 7'b0010011;
    localparam logic [6:0] OP_R_TYPE = 7'b0110011;

endpackage

// File: rtl/sm_if.sv
// Handshake between the state sequencer and the per-stage controller.
interface sm_if;
    import _riscv_defines::*;

    state_t     now_state;
    state_t     now_state_d1;
    state_t     next_state;
    logic       state_finish;
    logic [6:0] opcode;

    modport master (
        output state_finish, opcode,
        input  now_state, now_state_d1, next_state
    );

    modport slave (
        input  state_finish, opcode,
        output now_state, now_state_d1, next_state
    );
endinterface

// File: rtl/stage_ctrl.sv
// Per-stage controller: fetch, IR hold, data access, load extraction,
// writeback strobe and PC update, with a memory-stall watchdog.
module stage_ctrl
    import _riscv_defines::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    sm_if.master        sm,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    input  logic [31:0] ex_result,
    input  logic [31:0] ex_next_pc,
    input  logic [31:0] store_data,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        bus_err,
    output logic        misaligned,
    output logic        illegal
);
    localparam int unsigned CNT_W = 16;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic             run;
    logic [31:0]      result_q;
    logic [31:0]      load_q;
    logic [31:0]      addr_q;
    logic [CNT_W-1:0] tmo_cnt;
    logic [CNT_W-1:0] cnt_cur;

    logic [6:0]  opcode_w;
    logic [2:0]  funct3;
    logic [1:0]  lane;
    logic        is_load;
    logic        is_store;
    logic        legal;
    logic        mis_c;
    logic        first_cyc;
    logic        at_limit;
    logic        pend;
    logic        finish;
    logic        fetch_xfer;
    logic        fetch_tmo;
    logic        load_xfer;
    logic        mem_tmo;
    logic        mem_mis;
    logic [15:0] half_v;
    logic [7:0]  byte_v;
    logic [31:0] load_val;

    assign opcode_w        = instr[6:0];
    assign funct3          = instr[14:12];
    assign lane            = addr_q[1:0];
    assign is_load         = (opcode_w == OP_LOAD);
    assign is_store        = (opcode_w == OP_STORE);
    assign sm.opcode       = opcode_w;
    assign sm.state_finish = finish;

    assign imem_addr  = pc;
    assign dmem_addr  = {addr_q[31:2], 2'b00};
    assign dmem_we    = dmem_req & is_store;
    assign dmem_wdata = store_data << {lane, 3'b000};
    assign rf_waddr   = instr[11:7];
    assign rf_wdata   = is_load ? load_q : result_q;

    always_comb begin
        legal = 1'b0;
        case (opcode_w)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
            OP_LOAD, OP_STORE, OP_I_TYPE, OP_R_TYPE: legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    // Alignment check and byte enables, both sized by funct3[1:0]
    always_comb begin
        mis_c   = 1'b0;
        dmem_be = 4'b1111;
        case (funct3[1:0])
            2'b00: begin
                mis_c = 1'b0;
                if (is_store) dmem_be = 4'(4'b0001 << lane);
            end
            2'b01: begin
                mis_c = lane[0];
                if (is_store) dmem_be = 4'(4'b0011 << lane);
            end
            default: mis_c = (lane != 2'b00);
        endcase
    end

    always_comb begin
        half_v   = lane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        byte_v   = lane[0] ? half_v[15:8] : half_v[7:0];
        load_val = dmem_rdata;
        case (funct3)
            3'b000:  load_val = {{24{byte_v[7]}}, byte_v};
            3'b100:  load_val = {24'h000000, byte_v};
            3'b001:  load_val = {{16{half_v[15]}}, half_v};
            3'b101:  load_val = {16'h0000, half_v};
            default: load_val = dmem_rdata;
        endcase
    end

    // Stall count restarts on every new state visit
    assign first_cyc = (sm.now_state != sm.now_state_d1);
    assign cnt_cur   = first_cyc ? '0 : tmo_cnt;
    assign at_limit  = (cnt_cur == CNT_W'(TIMEOUT - 1));
    assign pend      = (imem_req & ~imem_ready) | (dmem_req & ~dmem_ready);

    always_comb begin
        finish     = 1'b0;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        rf_we      = 1'b0;
        fetch_xfer = 1'b0;
        fetch_tmo  = 1'b0;
        load_xfer  = 1'b0;
        mem_tmo    = 1'b0;
        mem_mis    = 1'b0;
        case (sm.now_state)
            FETCH: begin
                imem_req = run;
                if (run && imem_ready) begin
                    finish     = 1'b1;
                    fetch_xfer = 1'b1;
                end else if (run && at_limit) begin
                    finish    = 1'b1;
                    fetch_tmo = 1'b1;
                end
            end
            DECODE, EXECUTE: finish = 1'b1;
            MEMORY: begin
                if (!(is_load || is_store)) begin
                    finish = 1'b1;
                end else if (mis_c) begin
                    finish  = 1'b1;
                    mem_mis = 1'b1;
                end else begin
                    dmem_req = run;
                    if (run && dmem_ready) begin
                        finish    = 1'b1;
                        load_xfer = is_load;
                    end else if (run && at_limit) begin
                        finish  = 1'b1;
                        mem_tmo = 1'b1;
                    end
                end
            end
            WRITEBACK: begin
                finish = 1'b1;
                rf_we  = run && (instr[11:7] != 5'd0);
            end
            default: finish = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run        <= 1'b0;
            pc         <= RESET_PC;
            instr      <= NOP;
            result_q   <= '0;
            load_q     <= '0;
            addr_q     <= '0;
            tmo_cnt    <= '0;
            bus_err    <= 1'b0;
            misaligned <= 1'b0;
            illegal    <= 1'b0;
        end else begin
            run <= 1'b1;
            if (fetch_xfer)     instr <= imem_rdata;
            else if (fetch_tmo) instr <= NOP;
            if (sm.now_state == EXECUTE) begin
                result_q <= ex_result;
                addr_q   <= ex_result;
            end
            if (load_xfer)                             load_q <= load_val;
            else if (mem_mis || (mem_tmo && is_load))  load_q <= '0;
            if (fetch_tmo || mem_tmo) bus_err    <= 1'b1;
            if (mem_mis)              misaligned <= 1'b1;
            if (sm.now_state == DECODE && !legal) illegal <= 1'b1;
            if (finish && sm.next_state == FETCH) pc <= ex_next_pc;
            if (finish)         tmo_cnt <= '0;
            else if (pend)      tmo_cnt <= cnt_cur + CNT_W'(1);
            else if (first_cyc) tmo_cnt <= '0;
        end
    end
endmodule
